hazard_controller: RTL
======================

# hazard_controller

Pipeline hazard controller for the five-stage core. It generates the write-enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM stage registers. It resolves three hazards: load-use stalls, taken branch/jump squashes, and multi-cycle multiply/divide occupancy of the EX stage. A small state machine sequences the multiply/divide stall, and a saturating counter records total stall cycles for performance debug.

## Interface

Parameters:
- MULDIV_LATENCY, default 4: cycles a mul/div occupies EX; legal range 2..255.
- STALL_CNT_W, default 16: width of the stall-cycle performance counter.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- IDEX_MemRead  in  1  instruction in ID/EX is a load.
- IDEX_Rt  in  5  destination register of the instruction in ID/EX.
- IFID_Rs  in  5  source register Rs of the instruction in IF/ID.
- IFID_Rt  in  5  source register Rt of the instruction in IF/ID.
- Branch_Taken  in  1  branch in ID resolved taken this cycle.
- Jump  in  1  jump decoded in ID this cycle.
- IDEX_MulDiv  in  1  instruction in ID/EX is a mul/div.
- PC_WriteEnable  out  1  PC may update.
- IFID_WriteEnable  out  1  IF/ID may capture.
- IFID_Flush  out  1  clear IF/ID (squash fetched instruction).
- IDEX_WriteEnable  out  1  ID/EX may capture.
- IDEX_Flush  out  1  load bubble into ID/EX.
- EXMEM_Flush  out  1  load bubble into EX/MEM.
- MD_Busy  out  1  mul/div stall in progress.
- Stall_Count  out  STALL_CNT_W  saturating count of stalled cycles.

## Operation

- States: RUN and MD_WAIT. The 8-bit down-counter md_cnt is valid in MD_WAIT.
- Outputs are combinational from the state, md_cnt and the inputs.
- Defaults: all WriteEnables = 1, all Flushes = 0, MD_Busy = 0.
- Mul/div stall has the highest priority. It applies in RUN with IDEX_MulDiv = 1, or in MD_WAIT with md_cnt != 0:
  - PC_WriteEnable = IFID_WriteEnable = IDEX_WriteEnable = 0.
  - EXMEM_Flush = 1, MD_Busy = 1.
  - Branch_Taken, Jump and load-use are ignored.
- RUN with IDEX_MulDiv = 1: load md_cnt = MULDIV_LATENCY-1 and go to MD_WAIT.
- MD_WAIT with md_cnt != 0: decrement md_cnt.
- MD_WAIT with md_cnt == 0 (release cycle):
  - Outputs take default values; the mul/div result passes into EX/MEM.
  - Go to RUN.
  - Load-use and branch logic evaluate normally in this cycle.
- Load-use stall, evaluated in RUN with no mul/div stall:
  - Condition: IDEX_MemRead && IDEX_Rt != 0 && (IDEX_Rt == IFID_Rs || IDEX_Rt == IFID_Rt).
  - Response: PC_WriteEnable = 0, IFID_WriteEnable = 0, IDEX_Flush = 1.
  - Branch_Taken and Jump are suppressed this cycle, because their operands are not yet valid.
- Control squash, applied when no stall is active and (Branch_Taken || Jump):
  - IFID_Flush = 1; PC remains write-enabled so it loads the target.
- Stall_Count increments by 1 on each cycle where PC_WriteEnable = 0 and saturates at all-ones.
- Reset forces state RUN, md_cnt = 0 and Stall_Count = 0. While Reset is high, outputs take default values.

## Timing

- Load-use: exactly 1 stall cycle per hazard. In the next cycle the load is in MEM and the condition clears.
- Mul/div: exactly MULDIV_LATENCY stalled cycles (the entry cycle plus MULDIV_LATENCY-1 MD_WAIT cycles), then 1 release cycle.
- Branch/jump: zero stall and 1 flushed slot.
- Back-to-back mul/div: the release cycle captures the next instruction into ID/EX. If that instruction is a mul/div, it re-enters the stall in the next cycle from RUN. No overlap occurs.
- Reset asserted mid-MD_WAIT: state is RUN on the next edge, and no stale MD_Busy appears.
- Stall_Count updates one cycle after the stalled cycle.

## Test plan

- Load-use: IDEX_MemRead = 1, IDEX_Rt = 5, IFID_Rs = 5 for one cycle. Required: PC_WriteEnable = 0, IFID_WriteEnable = 0, IDEX_Flush = 1 for 1 cycle, then Stall_Count = 1.
- Load with Rt = 0: IDEX_MemRead = 1, IDEX_Rt = 0, IFID_Rs = 0. Required: no stall and all outputs at default.
- Mul/div with MULDIV_LATENCY = 4: IDEX_MulDiv held 1. Required: MD_Busy = 1 for 4 cycles with EXMEM_Flush = 1 and all enables 0, then 1 release cycle with default outputs, then Stall_Count = 4.
- Branch during a load-use stall, then after it: Branch_Taken = 1 together with the load-use condition gives IFID_Flush = 0. Branch_Taken = 1 in the following cycle alone gives IFID_Flush = 1 with PC_WriteEnable = 1.
- Reset at the 2nd MD_WAIT cycle: required MD_Busy = 0 on the next cycle, state RUN, and Stall_Count = 0.
- Saturation with STALL_CNT_W = 4: 20 consecutive load-use hazards. Required: Stall_Count holds at 15.

Source files
------------

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Purpose  : Stage-register enables/flushes for the five-stage core: load-use
//            stall, branch/jump squash and multi-cycle mul/div EX occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_controller #(
    parameter int MULDIV_LATENCY = 4,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   IDEX_MemRead,
    input  logic [4:0]             IDEX_Rt,
    input  logic [4:0]             IFID_Rs,
    input  logic [4:0]             IFID_Rt,
    input  logic                   Branch_Taken,
    input  logic                   Jump,
    input  logic                   IDEX_MulDiv,
    output logic                   PC_WriteEnable,
    output logic                   IFID_WriteEnable,
    output logic                   IFID_Flush,
    output logic                   IDEX_WriteEnable,
    output logic                   IDEX_Flush,
    output logic                   EXMEM_Flush,
    output logic                   MD_Busy,
    output logic [STALL_CNT_W-1:0] Stall_Count
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    localparam logic [7:0]             MD_RELOAD = 8'(MULDIV_LATENCY - 1);
    localparam logic [STALL_CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [STALL_CNT_W-1:0] CNT_ONE   = STALL_CNT_W'(1);

    state_t                   state_q, state_d;
    logic [7:0]               md_cnt_q, md_cnt_d;
    logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic                     md_stall;
    logic                     load_use_hit;
    logic                     ctrl_redirect;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_RUN;
            md_cnt_q    <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Mul/div sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        md_stall = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (IDEX_MulDiv) begin
                    md_stall = 1'b1;
                    md_cnt_d = MD_RELOAD;
                    state_d  = ST_MD_WAIT;
                end
            end
            ST_MD_WAIT: begin
                if (md_cnt_q != 8'd0) begin
                    md_stall = 1'b1;
                    md_cnt_d = md_cnt_q - 8'd1;
                end else begin
                    // Release cycle: the mul/div still sits in ID/EX, so
                    // IDEX_MulDiv is deliberately not looked at here.
                    md_cnt_d = 8'd0;
                    state_d  = ST_RUN;
                end
            end
            default: begin
                state_d  = ST_RUN;
                md_cnt_d = 8'd0;
            end
        endcase
    end

    assign load_use_hit  = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                           ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
    assign ctrl_redirect = Branch_Taken || Jump;

    // ------------------------------------------------------------------
    // Output decode: mul/div > load-use > branch/jump squash
    // ------------------------------------------------------------------
    always_comb begin
        PC_WriteEnable   = 1'b1;
        IFID_WriteEnable = 1'b1;
        IFID_Flush       = 1'b0;
        IDEX_WriteEnable = 1'b1;
        IDEX_Flush       = 1'b0;
        EXMEM_Flush      = 1'b0;
        MD_Busy          = 1'b0;
        if (!Reset) begin
            if (md_stall) begin
                PC_WriteEnable   = 1'b0;
                IFID_WriteEnable = 1'b0;
                IDEX_WriteEnable = 1'b0;
                EXMEM_Flush      = 1'b1;
                MD_Busy          = 1'b1;
            end else if (load_use_hit) begin
                // Branch operands are not valid yet, so no squash here.
                PC_WriteEnable   = 1'b0;
                IFID_WriteEnable = 1'b0;
                IDEX_Flush       = 1'b1;
            end else if (ctrl_redirect) begin
                IFID_Flush       = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PC_WriteEnable && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    assign Stall_Count = stall_cnt_q;

endmodule
`default_nettype wire
